bet_round_sequencer: RTL and testbench
======================================

Name: bet_round_sequencer

Overview:
Round controller for the roulette table. It captures keyboard/Arduino bets into a slot buffer and starts the wheel spin on the spin command. It then waits for the processor to report the settled number and streams the stored bets to the payout evaluator over a valid/ready handshake. It sits between keyboardToBet/Ps2Controller and the regfile/payout path, and replaces the ad-hoc bet latching and betCount logic in the top level.

Parameters:
MAX_BETS, 12, number of bet slots (1..15)
SPIN_TIMEOUT, 100000000, cycles allowed in SPIN before abort (>=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
bet_valid  in  1  one-cycle strobe; a new keyboard code has been decoded
bet_opcode  in  6  decoded bet opcode; 6'h3F = invalid, 6'h3E = spin command
bet_color  in  3  Arduino chip colour; 3'b000 = no chip
spin_done  in  1  one-cycle strobe from the processor; the wheel has settled
led_number  in  6  winning number, valid in the cycle spin_done is high
spin  out  1  high for the whole SPIN state
bet_count  out  4  number of stored bets
scan_valid  out  1  scan_slot/scan_index are valid
scan_slot  out  8  {bet_color[1:0], bet_opcode} of the presented slot
scan_index  out  4  index of the presented slot
scan_ready  in  1  payout evaluator accepts the presented slot
win_number  out  6  latched winning number of the current round
round_done  out  1  one-cycle pulse at the end of the round
bet_dropped  out  1  one-cycle pulse; a bet was rejected because the buffer is full
timeout  out  1  sticky; the last spin aborted. Cleared by reset or by the next accepted bet

Behaviour:
- States: BET, SPIN, SCAN, DONE. Reset value is BET. All outputs reset to 0, bet_count = 0, win_number = 0, slots = 0.
- Accepted bet, BET state only: bet_valid & bet_opcode not in {3F,3E} & bet_color != 0 & bet_count < MAX_BETS.
  - Next edge: slot[bet_count] <= {bet_color[1:0], bet_opcode}; bet_count++; timeout <= 0.
- Full: an otherwise-valid bet when bet_count == MAX_BETS is not stored; bet_dropped pulses in the following cycle.
- Invalid opcode (3F) or bet_color == 0: silently ignored, no pulse.
- Spin command: bet_valid & bet_opcode == 3E in BET.
  - If bet_count > 0: go to SPIN next edge; spin = 1 from that edge; timeout counter cleared.
  - If bet_count == 0: ignored. Never stored, colour is irrelevant.
- SPIN:
  - bet_valid is ignored.
  - On spin_done: win_number <= led_number, scan_index <= 0, go to SCAN. spin drops the same edge.
  - Counter reaches SPIN_TIMEOUT-1 without spin_done: clear bet_count, set timeout, go to BET.
  - spin_done and the timeout expiring in the same cycle: spin_done wins.
- SCAN:
  - scan_valid = 1 and scan_slot = slot[scan_index], both registered. Outputs hold stable until scan_valid & scan_ready.
  - On a handshake: if scan_index == bet_count-1, go to DONE (scan_valid drops); else scan_index++ and the next slot is presented on the following cycle. Minimum one slot per cycle.
- DONE: round_done = 1 for exactly one cycle; bet_count <= 0; go to BET. Slot contents need not be cleared.
- spin_done outside SPIN and scan_ready outside SCAN are ignored.
- Reset asserted in any state: immediate return to the reset values. A partial scan is discarded.
- Latency: bet_valid to bet_count update is 1 cycle. spin_done to first scan_valid is 1 cycle.

Optional Feature:
ROUND_HISTORY_EN
- Defined: add outputs last_number[5:0] and round_total[7:0].
  - At each DONE, last_number <= win_number and round_total++ (wraps 255 -> 0).
  - Timeouts do not count.
  - Both reset to 0.
- Undefined: the ports still exist, tied to 0; no extra registers.

Test Plan:
- Reset, 3 bets (op 5/col 1, op 12/col 2, op 0/col 3), spin command, spin_done with led_number 17, scan_ready held 1 -> scan_slot 0x45, 0x8C, 0xC0 on consecutive cycles; win_number 17; round_done pulse; bet_count returns to 0.
- Spin command with bet_count 0 -> state stays BET; spin stays 0.
- 13 valid bets with MAX_BETS 12 -> bet_count 12; bet_dropped pulses once, after the 13th.
- SPIN_TIMEOUT 8, no spin_done -> spin high for 8 cycles; timeout = 1; bet_count 0; the next accepted bet clears timeout.
- In SCAN, scan_ready low for 4 cycles, then high -> scan_slot and scan_index stable throughout; scan_index advances only on the handshake.
- Assert reset mid-SCAN at index 1 of 3 -> all outputs 0 asynchronously; the next round works normally. With ROUND_HISTORY_EN, two full rounds -> round_total 2, last_number = second win_number.

Source files
------------

// File: rtl/bet_round_sequencer.sv
// bet_round_sequencer: roulette round controller.
// Collects bets into a slot buffer while in BET and starts the wheel on the
// spin command. It then waits for the settled number, or aborts after
// SPIN_TIMEOUT cycles. Finally it streams the stored slots to the payout
// evaluator over a valid/ready handshake.
// Optional build macro ROUND_HISTORY_EN enables the last_number/round_total
// history registers; without it those ports are tied to zero.
module bet_round_sequencer #(
    parameter int MAX_BETS     = 12,
    parameter int SPIN_TIMEOUT = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bet_valid,
    input  logic [5:0] bet_opcode,
    input  logic [2:0] bet_color,
    input  logic       spin_done,
    input  logic [5:0] led_number,
    output logic       spin,
    output logic [3:0] bet_count,
    output logic       scan_valid,
    output logic [7:0] scan_slot,
    output logic [3:0] scan_index,
    input  logic       scan_ready,
    output logic [5:0] win_number,
    output logic       round_done,
    output logic       bet_dropped,
    output logic       timeout,
    output logic [5:0] last_number,
    output logic [7:0] round_total
);

    localparam int TW = (SPIN_TIMEOUT > 2) ? $clog2(SPIN_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_BET  = 2'd0,
        ST_SPIN = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [7:0]      slots_q [MAX_BETS];
    logic [3:0]      bet_count_q;
    logic            spin_q;
    logic            scan_valid_q;
    logic [7:0]      scan_slot_q;
    logic [3:0]      scan_index_q;
    logic [5:0]      win_number_q;
    logic            round_done_q;
    logic            bet_dropped_q;
    logic            timeout_q;
    logic [TW-1:0]   tmr_q;

    logic            bet_ok_s;
    logic            room_s;
    logic            spin_cmd_s;
    logic            last_slot_s;
    logic            tmr_exp_s;
    logic [3:0]      idx_nxt_s;
    logic [7:0]      scan_slot_d;

    // Decode the incoming strobe and the FSM-side conditions.
    always_comb begin
        bet_ok_s    = bet_valid && (bet_opcode != 6'h3F) && (bet_opcode != 6'h3E) && (|bet_color);
        room_s      = bet_count_q < 4'(MAX_BETS);
        spin_cmd_s  = bet_valid && (bet_opcode == 6'h3E);
        last_slot_s = scan_index_q == (bet_count_q - 4'd1);
        tmr_exp_s   = tmr_q == TW'(SPIN_TIMEOUT - 1);
        idx_nxt_s   = scan_index_q + 4'd1;
    end

    // One-hot OR mux selecting the slot that follows the presented one.
    always_comb begin
        scan_slot_d = 8'h00;
        for (int i = 0; i < MAX_BETS; i++) begin
            scan_slot_d = scan_slot_d | (slots_q[i] & {8{idx_nxt_s == 4'(i)}});
        end
    end

    // Round FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BET;
            bet_count_q   <= 4'd0;
            spin_q        <= 1'b0;
            scan_valid_q  <= 1'b0;
            scan_slot_q   <= 8'h00;
            scan_index_q  <= 4'd0;
            win_number_q  <= 6'd0;
            round_done_q  <= 1'b0;
            bet_dropped_q <= 1'b0;
            timeout_q     <= 1'b0;
            tmr_q         <= '0;
            for (int i = 0; i < MAX_BETS; i++) begin
                slots_q[i] <= 8'h00;
            end
        end else begin
            round_done_q  <= 1'b0;
            bet_dropped_q <= 1'b0;
            case (state_q)
                ST_BET: begin
                    if (bet_ok_s && room_s) begin
                        for (int i = 0; i < MAX_BETS; i++) begin
                            if (bet_count_q == 4'(i)) begin
                                slots_q[i] <= {bet_color[1:0], bet_opcode};
                            end
                        end
                        bet_count_q <= bet_count_q + 4'd1;
                        timeout_q   <= 1'b0;
                    end else if (bet_ok_s) begin
                        bet_dropped_q <= 1'b1;
                    end else if (spin_cmd_s && (bet_count_q != 4'd0)) begin
                        state_q <= ST_SPIN;
                        spin_q  <= 1'b1;
                        tmr_q   <= '0;
                    end
                end
                ST_SPIN: begin
                    // spin_done takes priority over an expiring timer
                    if (spin_done) begin
                        win_number_q <= led_number;
                        scan_index_q <= 4'd0;
                        scan_slot_q  <= slots_q[0];
                        scan_valid_q <= 1'b1;
                        spin_q       <= 1'b0;
                        state_q      <= ST_SCAN;
                    end else if (tmr_exp_s) begin
                        bet_count_q <= 4'd0;
                        timeout_q   <= 1'b1;
                        spin_q      <= 1'b0;
                        state_q     <= ST_BET;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                ST_SCAN: begin
                    if (scan_valid_q && scan_ready) begin
                        if (last_slot_s) begin
                            scan_valid_q <= 1'b0;
                            round_done_q <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            scan_index_q <= idx_nxt_s;
                            scan_slot_q  <= scan_slot_d;
                        end
                    end
                end
                ST_DONE: begin
                    bet_count_q <= 4'd0;
                    state_q     <= ST_BET;
                end
                default: begin
                    state_q <= ST_BET;
                end
            endcase
        end
    end

`ifdef ROUND_HISTORY_EN
    logic [5:0] last_number_q;
    logic [7:0] round_total_q;

    // Record the finished round's number and count completed rounds.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_number_q <= 6'd0;
            round_total_q <= 8'd0;
        end else if (state_q == ST_DONE) begin
            last_number_q <= win_number_q;
            round_total_q <= round_total_q + 8'd1;
        end
    end

    assign last_number = last_number_q;
    assign round_total = round_total_q;
`else
    assign last_number = 6'd0;
    assign round_total = 8'd0;
`endif

    assign spin        = spin_q;
    assign bet_count   = bet_count_q;
    assign scan_valid  = scan_valid_q;
    assign scan_slot   = scan_slot_q;
    assign scan_index  = scan_index_q;
    assign win_number  = win_number_q;
    assign round_done  = round_done_q;
    assign bet_dropped = bet_dropped_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_bet_round_sequencer.sv
// Self-checking bench for bet_round_sequencer (MAX_BETS 12, SPIN_TIMEOUT 8).
module tb_bet_round_sequencer;

    localparam int MAXB = 12;
    localparam int TMO  = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       bet_valid = 1'b0;
    logic [5:0] bet_opcode = 6'd0;
    logic [2:0] bet_color = 3'd0;
    logic       spin_done = 1'b0;
    logic [5:0] led_number = 6'd0;
    logic       scan_ready = 1'b0;
    logic       spin, scan_valid, round_done, bet_dropped, timeout;
    logic [3:0] bet_count, scan_index;
    logic [7:0] scan_slot, round_total;
    logic [5:0] win_number, last_number;

    int n_vec = 0;
    int n_err = 0;
    int exp_count = 0;
    logic exp_timeout = 1'b0;
    logic [7:0] sb [$];

    bet_round_sequencer #(.MAX_BETS(MAXB), .SPIN_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .bet_valid(bet_valid), .bet_opcode(bet_opcode),
        .bet_color(bet_color), .spin_done(spin_done), .led_number(led_number),
        .spin(spin), .bet_count(bet_count), .scan_valid(scan_valid), .scan_slot(scan_slot),
        .scan_index(scan_index), .scan_ready(scan_ready), .win_number(win_number),
        .round_done(round_done), .bet_dropped(bet_dropped), .timeout(timeout),
        .last_number(last_number), .round_total(round_total)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Drive one keyboard strobe in BET and check the model's view of it.
    task automatic do_bet(input logic [5:0] op, input logic [2:0] col);
        logic ok, drop;
        @(negedge clock);
        bet_valid = 1'b1; bet_opcode = op; bet_color = col;
        ok   = (op != 6'h3F) && (op != 6'h3E) && (col != 3'd0);
        drop = ok && (exp_count == MAXB);
        if (ok && exp_count < MAXB) begin
            sb.push_back({col[1:0], op});
            exp_count++;
            exp_timeout = 1'b0;
        end
        @(negedge clock);
        bet_valid = 1'b0;
        n_vec++;
        if (bet_count !== 4'(exp_count)) begin
            n_err++; $display("FAIL bet_count: got %0d expected %0d", bet_count, exp_count);
        end
        n_vec++;
        if (bet_dropped !== drop) begin
            n_err++; $display("FAIL bet_dropped: got %0b expected %0b", bet_dropped, drop);
        end
        n_vec++;
        if (timeout !== exp_timeout) begin
            n_err++; $display("FAIL timeout_after_bet: got %0b expected %0b", timeout, exp_timeout);
        end
    endtask

    task automatic spin_cmd(input logic [2:0] col);
        logic want;
        @(negedge clock);
        bet_valid = 1'b1; bet_opcode = 6'h3E; bet_color = col;
        want = (exp_count > 0);
        @(negedge clock);
        bet_valid = 1'b0;
        n_vec++;
        if (spin !== want) begin
            n_err++; $display("FAIL spin_cmd: got %0b expected %0b", spin, want);
        end
    endtask

    task automatic do_spin_done(input logic [5:0] led);
        @(negedge clock);
        spin_done = 1'b1; led_number = led;
        @(negedge clock);
        spin_done = 1'b0; led_number = 6'd0;
        n_vec++;
        if (spin !== 1'b0 || scan_valid !== 1'b1) begin
            n_err++; $display("FAIL spin_to_scan: got spin %0b valid %0b expected 0 1", spin, scan_valid);
        end
        n_vec++;
        if (win_number !== led) begin
            n_err++; $display("FAIL win_number: got %0d expected %0d", win_number, led);
        end
    endtask

    // Consume the scan stream, comparing each handshaken slot against the scoreboard.
    task automatic run_scan(input int stall);
        int waited, stall_cnt, exp_idx;
        logic got_done, prev_stalled;
        logic [7:0] prev_slot, exp_slot;
        logic [3:0] prev_idx;
        waited = 0; stall_cnt = 0; exp_idx = 0;
        got_done = 1'b0; prev_stalled = 1'b0; prev_slot = 8'h00; prev_idx = 4'd0;
        while (!got_done && waited < 300) begin
            @(negedge clock);
            waited++;
            if (round_done) begin
                got_done = 1'b1;
                scan_ready = 1'b0;
            end else if (scan_valid) begin
                if (prev_stalled) begin
                    n_vec++;
                    if (scan_slot !== prev_slot || scan_index !== prev_idx) begin
                        n_err++;
                        $display("FAIL stall_hold: got %0h/%0d expected %0h/%0d", scan_slot, scan_index, prev_slot, prev_idx);
                    end
                end
                if (stall_cnt < stall) begin
                    stall_cnt++;
                    scan_ready = 1'b0;
                    prev_stalled = 1'b1;
                    prev_slot = scan_slot;
                    prev_idx = scan_index;
                end else begin
                    scan_ready = 1'b1;
                    prev_stalled = 1'b0;
                    stall_cnt = 0;
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++; $display("FAIL scan_extra: got slot %0h expected none", scan_slot);
                    end else begin
                        exp_slot = sb.pop_front();
                        if (scan_slot !== exp_slot || scan_index !== 4'(exp_idx)) begin
                            n_err++;
                            $display("FAIL scan_slot: got %0h/%0d expected %0h/%0d", scan_slot, scan_index, exp_slot, exp_idx);
                        end
                    end
                    exp_idx++;
                end
            end else begin
                scan_ready = 1'b0;
            end
        end
        scan_ready = 1'b0;
        n_vec++;
        if (!got_done) begin
            n_err++; $display("FAIL round_done_timeout: got 0 expected 1");
        end
        chk("scan_leftover", sb.size(), 0);
        @(negedge clock);
        n_vec++;
        if (round_done !== 1'b0 || bet_count !== 4'd0 || scan_valid !== 1'b0) begin
            n_err++;
            $display("FAIL round_end: got done %0b count %0d valid %0b expected 0 0 0", round_done, bet_count, scan_valid);
        end
        exp_count = 0;
    endtask

    task automatic test_reset;
        #12;
        n_vec++;
        if ({spin, bet_count, scan_valid, scan_slot, scan_index, win_number, round_done,
             bet_dropped, timeout, last_number, round_total} !== 46'd0) begin
            n_err++; $display("FAIL reset_state: got nonzero output expected all zero");
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_round;
        do_bet(6'd5, 3'd1);
        do_bet(6'd12, 3'd2);
        do_bet(6'd0, 3'd3);
        spin_cmd(3'd0);
        do_spin_done(6'd17);
        run_scan(0);
    endtask

    task automatic test_spin_empty;
        spin_cmd(3'd5);
        repeat (3) @(negedge clock);
        chk("empty_spin_hold", spin, 0);
        do_bet(6'h3F, 3'd2);
        do_bet(6'd9, 3'd0);
        @(negedge clock);
        spin_done = 1'b1; led_number = 6'd3;
        @(negedge clock);
        spin_done = 1'b0;
        chk("spin_done_ignored", scan_valid, 0);
        chk("win_unchanged", win_number, 17);
    endtask

    task automatic test_full;
        for (int i = 0; i < 13; i++) begin
            do_bet(6'(i + 1), 3'((i % 3) + 1));
        end
        @(negedge clock);
        chk("drop_single_pulse", bet_dropped, 0);
        spin_cmd(3'd1);
        do_spin_done(6'd36);
        run_scan(0);
    endtask

    task automatic test_timeout;
        int highs;
        do_bet(6'd21, 3'd4);
        do_bet(6'd22, 3'd1);
        spin_cmd(3'd0);
        highs = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (spin) highs++;
            else break;
        end
        chk("spin_cycles", highs, TMO);
        chk("timeout_set", timeout, 1);
        chk("timeout_count", bet_count, 0);
        sb.delete();
        exp_count = 0;
        exp_timeout = 1'b1;
        do_bet(6'h3F, 3'd1);
        do_bet(6'd30, 3'd2);
    endtask

    task automatic test_stall;
        do_bet(6'd1, 3'd3);
        do_bet(6'd2, 3'd2);
        spin_cmd(3'd0);
        do_spin_done(6'd33);
        run_scan(4);
    endtask

    task automatic full_round(input logic [5:0] led);
        do_bet(6'd10, 3'd1);
        do_bet(6'd11, 3'd6);
        spin_cmd(3'd0);
        do_spin_done(led);
        run_scan(1);
    endtask

    task automatic test_reset_mid_scan;
        int waited;
        do_bet(6'd7, 3'd4);
        do_bet(6'd20, 3'd2);
        do_bet(6'd33, 3'd1);
        spin_cmd(3'd0);
        do_spin_done(6'd25);
        scan_ready = 1'b1;
        waited = 0;
        while (scan_index !== 4'd1 && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        scan_ready = 1'b0;
        chk("mid_scan_index", scan_index, 1);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({spin, bet_count, scan_valid, scan_slot, scan_index, win_number, round_done,
             bet_dropped, timeout, last_number, round_total} !== 46'd0) begin
            n_err++; $display("FAIL async_reset: got nonzero output expected all zero");
        end
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        exp_count = 0;
        exp_timeout = 1'b0;
        full_round(6'd9);
        full_round(6'd40);
`ifdef ROUND_HISTORY_EN
        chk("round_total", round_total, 2);
        chk("last_number", last_number, 40);
`else
        chk("round_total_tied", round_total, 0);
        chk("last_number_tied", last_number, 0);
`endif
    endtask

    initial begin
        test_reset;
        test_round;
        test_spin_empty;
        test_full;
        test_timeout;
        spin_cmd(3'd0);
        do_spin_done(6'd12);
        run_scan(0);
        test_stall;
        test_reset_mid_scan;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
